// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a combinational hit path
// and a byte-serial refill from the memory arbiter.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] next_PC,
  input  logic        next_inst,
  output logic        cache_rdy,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_byte
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, REFILL, INSTALL} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             buf_q, buf_d;
  logic [LINES-1:0]        valid_q, valid_d;

  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   idx;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        lkp_tag;
  logic                    hit;
  logic                    install_en;

  assign idx        = next_PC[INDEX_BITS+1:2];
  assign lkp_tag    = next_PC[31:INDEX_BITS+2];
  assign fill_idx   = base_q[INDEX_BITS+1:2];
  assign hit        = valid_q[idx] && (tag_mem[idx] == lkp_tag);
  assign install_en = rdy_in && (state_q == INSTALL);

  // State and refill bookkeeping registers; rdy_in low leaves every *_d equal to *_q.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (install_en && !rst_in) begin
      tag_mem[fill_idx]  <= base_q[31:INDEX_BITS+2];
      data_mem[fill_idx] <= buf_q;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (next_inst && !hit) begin
            state_d = REFILL;
            base_d  = {next_PC[31:2], 2'b00};
            cnt_d   = '0;
          end
        end
        REFILL: begin
          if (mem_valid) begin
            buf_d[{cnt_q, 3'b000} +: 8] = mem_byte;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = INSTALL;
          end
        end
        INSTALL: begin
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cache_rdy = (state_q == IDLE) && rdy_in && next_inst && hit;
    inst      = data_mem[idx];
    mem_req   = (state_q == REFILL);
    mem_addr  = base_q + {30'b0, cnt_q};
  end

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: a line-content reference model plus a byte memory
// responder with configurable wait cycles, checked every cycle.
module tb_icache;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, next_inst, mem_valid;
  logic [31:0] next_PC;
  logic        cache_rdy, mem_req;
  logic [31:0] inst, mem_addr;
  logic [7:0]  mem_byte;

  icache #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .next_PC(next_PC), .next_inst(next_inst),
    .cache_rdy(cache_rdy), .inst(inst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_byte(mem_byte)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Backing memory (read-only) and reference model of which word each line holds.
  logic [7:0]  mem_arr [65536];
  bit          line_valid [LINES];
  int unsigned line_word [LINES];
  bit          refilling, installing;
  int unsigned fill_base;
  int          bytes_got;
  int          wait_n, wait_ctr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] w;
    w = {a[15:2], 2'b00};
    return {mem_arr[w+16'd3], mem_arr[w+16'd2], mem_arr[w+16'd1], mem_arr[w]};
  endfunction

  // One clock cycle: drive inputs, answer the memory port, check outputs, advance the model.
  task automatic run_cycle(input logic r, input logic n, input logic [31:0] pc, input logic rs,
                           output logic got_rdy);
    int  line;
    bit  exp_hit;
    bit  model_idle;
    rst_in = rs; rdy_in = r; next_inst = n; next_PC = pc;
    mem_valid = 1'b0;
    mem_byte  = 8'($urandom);
    if (mem_req && r && !rs) begin
      if (wait_ctr >= wait_n) begin
        mem_valid = 1'b1;
        mem_byte  = mem_arr[mem_addr[15:0]];
        wait_ctr  = 0;
      end else begin
        wait_ctr++;
      end
    end else if (!r || $urandom_range(0, 3) == 0) begin
      mem_valid = 1'b1;
    end
    #1;
    line       = int'(pc[7:2]);
    exp_hit    = line_valid[line] && (line_word[line] == {2'b00, pc[31:2]});
    model_idle = !refilling && !installing;
    check_eq("mem_req", {31'b0, mem_req}, {31'b0, refilling});
    if (refilling) check_eq("mem_addr", mem_addr, fill_base + 32'(bytes_got));
    check_eq("cache_rdy", {31'b0, cache_rdy}, {31'b0, model_idle && r && n && exp_hit});
    if (model_idle && r && n && exp_hit) check_eq("inst", inst, mem_word(pc));
    got_rdy = cache_rdy;
    @(posedge clk);
    if (rs) begin
      foreach (line_valid[i]) line_valid[i] = 1'b0;
      refilling = 1'b0; installing = 1'b0; wait_ctr = 0;
    end else if (r) begin
      if (installing) begin
        line_valid[fill_base[7:2]] = 1'b1;
        line_word[fill_base[7:2]]  = fill_base >> 2;
        installing = 1'b0;
        $display("install line=%0d base=0x%08h word=0x%08h", fill_base[7:2], fill_base, mem_word(fill_base));
      end else if (refilling) begin
        if (mem_valid) begin
          bytes_got++;
          if (bytes_got == 4) begin
            refilling  = 1'b0;
            installing = 1'b1;
          end
        end
      end else if (n && !exp_hit) begin
        refilling = 1'b1;
        fill_base = {pc[31:2], 2'b00};
        bytes_got = 0;
      end
    end
    @(negedge clk);
  endtask

  // Holds pc until the cache answers; returns cycles from the first request (-1 if it never does).
  task automatic measure(input logic [31:0] pc, input int w, output int lat);
    logic g;
    wait_n = w;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      run_cycle(1'b1, 1'b1, pc, 1'b0, g);
      if (g) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    logic        g;
    int          lat;
    logic [31:0] pc;
    foreach (mem_arr[i]) mem_arr[i] = 8'($urandom);
    mem_arr[0] = 8'h13; mem_arr[1] = 8'h05; mem_arr[2] = 8'h10; mem_arr[3] = 8'h00;
    refilling = 1'b0; installing = 1'b0; wait_n = 0; wait_ctr = 0;
    foreach (line_valid[i]) line_valid[i] = 1'b0;
    rst_in = 1'b1; rdy_in = 1'b1; next_inst = 1'b0; next_PC = '0; mem_valid = 1'b0; mem_byte = '0;
    @(negedge clk);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, g);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, g);
    rst_in = 1'b0; next_inst = 1'b0; #1;
    check_eq("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("reset_mem_addr", mem_addr, 32'd0);
    check_eq("reset_cache_rdy", {31'b0, cache_rdy}, 32'd0);
    @(negedge clk);

    measure(32'h0, 0, lat);
    check_eq("lat_first_fill", 32'(lat), 32'd6);
    rst_in = 1'b0; rdy_in = 1'b1; next_inst = 1'b1; next_PC = 32'h0; #1;
    check_eq("first_word", inst, 32'h00100513);
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1, 32'h0, 1'b0, g);

    measure(32'h4, 0, lat);
    check_eq("lat_miss_0x4", 32'(lat), 32'd6);
    measure(32'h0, 0, lat);
    check_eq("lat_hit_0x0", 32'(lat), 32'd0);

    measure(32'h100, 0, lat);
    check_eq("lat_conflict_0x100", 32'(lat), 32'd6);
    measure(32'h0, 0, lat);
    check_eq("lat_evicted_0x0", 32'(lat), 32'd6);

    measure(32'h300, 3, lat);
    check_eq("lat_wait3", 32'(lat), 32'(4 * (3 + 1) + 2));

    wait_n = 0;
    run_cycle(1'b1, 1'b1, 32'h40, 1'b0, g);
    measure(32'h80, 0, lat);
    check_eq("lat_redirect_0x80", 32'(lat), 32'd11);
    measure(32'h40, 0, lat);
    check_eq("lat_redirect_0x40_hit", 32'(lat), 32'd0);

    run_cycle(1'b1, 1'b1, 32'h200, 1'b0, g);
    run_cycle(1'b1, 1'b1, 32'h200, 1'b0, g);
    run_cycle(1'b1, 1'b1, 32'h200, 1'b0, g);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 32'h200, 1'b0, g);
    check_eq("stall_mem_addr", mem_addr, 32'h202);
    measure(32'h200, 0, lat);
    check_eq("lat_after_stall", 32'(lat), 32'd3);

    pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        pc = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      wait_n = $urandom_range(0, 2);
      run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, pc,
                $urandom_range(0, 399) == 0, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
